ram_hs_param: RTL

RAM_HS_PARAM -- requirements
Module: ram_hs_param

---
 rtl/ram_hs_param_if.sv | 34 +++
 rtl/ram_hs_param.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ram_hs_param_if.sv
// Bus bundle for ram_hs_param: request handshake, payload and completion status.
//   MOV      master->slave  request valid, held high by the master until MOC/ERR is seen
//   RW       master->slave  1 = read (load), 0 = write (store)
//   Address  master->slave  byte address, ADDR_W bits
//   OpCode   master->slave  6-bit MIPS load/store opcode (size and extension)
//   DataIn   master->slave  right-justified store data
//   DataOut  slave->master  right-justified, extended load data
//   MOC      slave->master  operation complete
//   ERR      slave->master  request rejected
//   BUSY     slave->master  slave is not idle
interface ram_hs_param_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
);
    logic              MOV;
    logic              RW;
    logic [ADDR_W-1:0] Address;
    logic [5:0]        OpCode;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              MOC;
    logic              ERR;
    logic              BUSY;

    modport master (
        output MOV, RW, Address, OpCode, DataIn,
        input  DataOut, MOC, ERR, BUSY
    );

    modport slave (
        input  MOV, RW, Address, OpCode, DataIn,
        output DataOut, MOC, ERR, BUSY
    );
endinterface

// File: rtl/ram_hs_param.sv
// Big-endian byte-addressed RAM with a MOV/MOC handshake and MIPS-style
// byte/half/word loads and stores, plus a programmable number of wait states.
//   clk    rising-edge clock
//   reset  asynchronous, active-low; memory contents survive it
//   bus    ram_hs_param_if slave modport (MOV/RW/Address/OpCode/DataIn in,
//          DataOut/MOC/ERR/BUSY out)
module ram_hs_param #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DATA_W      = 32
) (
    input logic           clk,
    input logic           reset,
    ram_hs_param_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;
    localparam logic [1:0] SzWord = 2'd2;

    typedef enum logic [1:0] {StIdle, StWait, StDone, StFail} state_t;

    typedef struct packed {
        logic       valid;
        logic       load;
        logic [1:0] size;
        logic       sext;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] opc);
        dec_t d;
        d = '0;
        case (opc)
            6'b100000: d = '{valid: 1'b1, load: 1'b1, size: SzByte, sext: 1'b1};
            6'b100100: d = '{valid: 1'b1, load: 1'b1, size: SzByte, sext: 1'b0};
            6'b100001: d = '{valid: 1'b1, load: 1'b1, size: SzHalf, sext: 1'b1};
            6'b100101: d = '{valid: 1'b1, load: 1'b1, size: SzHalf, sext: 1'b0};
            6'b100011: d = '{valid: 1'b1, load: 1'b1, size: SzWord, sext: 1'b0};
            6'b101000: d = '{valid: 1'b1, load: 1'b0, size: SzByte, sext: 1'b0};
            6'b101001: d = '{valid: 1'b1, load: 1'b0, size: SzHalf, sext: 1'b0};
            6'b101011: d = '{valid: 1'b1, load: 1'b0, size: SzWord, sext: 1'b0};
            default:   d = '0;
        endcase
        return d;
    endfunction

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_moc;
    logic              r_err;
    logic [DATA_W-1:0] r_dout;
    // Captured request; the opcode is held in decoded form (size + extension).
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [DATA_W-1:0] r_din;
    logic [7:0]        r_mem [DEPTH];

    dec_t              w_in_dec;
    logic              w_in_aligned;
    logic              w_in_legal;
    logic              w_access;
    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;
    logic [ADDR_W-1:0] w_a3;
    logic [7:0]        w_b0;
    logic [7:0]        w_b1;
    logic [7:0]        w_b2;
    logic [7:0]        w_b3;
    logic [DATA_W-1:0] w_load_val;

    assign w_in_dec = decode(bus.OpCode);

    always_comb begin
        w_in_aligned = 1'b1;
        case (w_in_dec.size)
            SzHalf:  w_in_aligned = ~bus.Address[0];
            SzWord:  w_in_aligned = (bus.Address[1:0] == 2'b00);
            default: w_in_aligned = 1'b1;
        endcase
    end

    assign w_in_legal = w_in_dec.valid && (w_in_dec.load == bus.RW) && w_in_aligned;

    // The access fires on the edge that sees the wait counter at zero.
    assign w_access = (r_state == StWait) && (r_cnt == 4'd0);

    // Alignment is checked at capture, so these never wrap past the top.
    assign w_a1 = r_addr + ADDR_W'(1);
    assign w_a2 = r_addr + ADDR_W'(2);
    assign w_a3 = r_addr + ADDR_W'(3);
    assign w_b0 = r_mem[r_addr];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    always_comb begin
        w_load_val = '0;
        case (r_size)
            SzByte:  w_load_val = {{24{r_sext & w_b0[7]}}, w_b0};
            SzHalf:  w_load_val = {{16{r_sext & w_b0[7]}}, w_b0, w_b1};
            default: w_load_val = {w_b0, w_b1, w_b2, w_b3};
        endcase
    end

    // Storage has no reset; reset only parks the FSM, which blocks w_access.
    always_ff @(posedge clk) begin
        if (w_access && !r_rw) begin
            case (r_size)
                SzByte: r_mem[r_addr] <= r_din[7:0];
                SzHalf: begin
                    r_mem[r_addr] <= r_din[15:8];
                    r_mem[w_a1]   <= r_din[7:0];
                end
                default: begin
                    r_mem[r_addr] <= r_din[31:24];
                    r_mem[w_a1]   <= r_din[23:16];
                    r_mem[w_a2]   <= r_din[15:8];
                    r_mem[w_a3]   <= r_din[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_moc   <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= '0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_size  <= SzByte;
            r_sext  <= 1'b0;
            r_din   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.MOV) begin
                        r_addr <= bus.Address;
                        r_rw   <= bus.RW;
                        r_size <= w_in_dec.size;
                        r_sext <= w_in_dec.sext;
                        r_din  <= bus.DataIn;
                        if (w_in_legal) begin
                            r_cnt   <= 4'(WAIT_CYCLES);
                            r_state <= StWait;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= StFail;
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        if (r_rw) begin
                            r_dout <= w_load_val;
                        end
                        r_moc   <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StDone, StFail: begin
                    if (!bus.MOV) begin
                        r_moc   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.DataOut = r_dout;
    assign bus.MOC     = r_moc;
    assign bus.ERR     = r_err;
    assign bus.BUSY    = (r_state != StIdle);
endmodule
